dm_store_ram: RTL and testbench

//   M-stage data memory: word-organised RAM with sb/sh/sw byte-lane write merging and async word read.

---
 rtl/dm_store_ram_if.sv | 21 ++
 rtl/dm_store_ram.sv | 138 +++++++++++++
 tb/tb_dm_store_ram.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/dm_store_ram_if.sv
// M-stage data-memory port bundle: store request from the pipeline, read data and status back.
interface dm_store_ram_if;
    logic [5:0]  Op;
    logic [31:0] ALU_Out_M;
    logic [31:0] WD_M;
    logic [31:0] PC_M;
    logic        Flush_M;
    logic [31:0] DM_Out;
    logic        DM_Busy;
    logic        SW_EXP;

    modport master (
        output Op, ALU_Out_M, WD_M, PC_M, Flush_M,
        input  DM_Out, DM_Busy, SW_EXP
    );

    modport slave (
        input  Op, ALU_Out_M, WD_M, PC_M, Flush_M,
        output DM_Out, DM_Busy, SW_EXP
    );
endinterface

// File: rtl/dm_store_ram.sv
// M-stage data memory: byte-lane merging stores, async word read, self-clear after reset.
// Optional DM_TRACE_EN prints every committed store.
module dm_store_ram #(
    parameter int unsigned ADDR_W = 10
) (
    input  logic           clk,
    input  logic           reset,
    dm_store_ram_if.slave  bus
);
    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam logic [5:0]  OP_SB = 6'b101000;
    localparam logic [5:0]  OP_SH = 6'b101001;
    localparam logic [5:0]  OP_SW = 6'b101011;

    typedef enum logic {CLEAR, IDLE} state_t;

    state_t              state;
    state_t              state_nx;
    logic [ADDR_W-1:0]   ptr;
    logic [ADDR_W-1:0]   ptr_nx;
    logic [31:0]         mem [DEPTH];

    logic [ADDR_W-1:0]   widx;
    logic [31:0]         rd_word;
    logic                busy_c;
    logic                is_sb;
    logic                is_sh;
    logic                is_sw;
    logic                store_c;
    logic                inr_c;
    logic                sw_exp_c;
    logic                we_c;
    logic [3:0]          be_c;
    logic [31:0]         lane_c;
    logic [31:0]         merged_c;
    logic [31:0]         dm_out_c;

    assign widx    = bus.ALU_Out_M[ADDR_W+1:2];
    assign rd_word = mem[widx];

    // State register; reset restarts the clear sweep from word 0
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= CLEAR;
            ptr   <= '0;
        end else begin
            state <= state_nx;
            ptr   <= ptr_nx;
        end
    end

    // Next state: sweep ptr over every word, leave after the last one
    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        case (state)
            CLEAR: begin
                ptr_nx = ptr + ADDR_W'(1);
                if (ptr == ADDR_W'(DEPTH - 1)) begin
                    state_nx = IDLE;
                    ptr_nx   = '0;
                end
            end
            IDLE:    state_nx = IDLE;
            default: state_nx = CLEAR;
        endcase
    end

    // Outputs: store decode, legality, lane enables and merged write word
    always_comb begin
        busy_c   = 1'b0;
        is_sb    = 1'b0;
        is_sh    = 1'b0;
        is_sw    = 1'b0;
        store_c  = 1'b0;
        inr_c    = 1'b0;
        sw_exp_c = 1'b0;
        we_c     = 1'b0;
        be_c     = 4'b0000;
        lane_c   = bus.WD_M;
        merged_c = rd_word;
        dm_out_c = 32'h0;

        busy_c   = (state == CLEAR);
        is_sb    = (bus.Op == OP_SB);
        is_sh    = (bus.Op == OP_SH);
        is_sw    = (bus.Op == OP_SW);
        store_c  = is_sb || is_sh || is_sw;
        inr_c    = (bus.ALU_Out_M[31:ADDR_W+2] == '0);
        sw_exp_c = store_c && (!inr_c || (is_sh && bus.ALU_Out_M[0])
                               || (is_sw && (bus.ALU_Out_M[1:0] != 2'b00)));
        we_c     = store_c && !sw_exp_c && !bus.Flush_M && !busy_c;

        if (is_sw) begin
            be_c   = 4'b1111;
            lane_c = bus.WD_M;
        end else if (is_sh) begin
            be_c   = bus.ALU_Out_M[1] ? 4'b1100 : 4'b0011;
            lane_c = {2{bus.WD_M[15:0]}};
        end else if (is_sb) begin
            be_c   = 4'b0001 << bus.ALU_Out_M[1:0];
            lane_c = {4{bus.WD_M[7:0]}};
        end

        for (int i = 0; i < 4; i++) begin
            if (be_c[i]) begin
                merged_c[8*i +: 8] = lane_c[8*i +: 8];
            end
        end

        dm_out_c = busy_c ? 32'h0 : rd_word;
    end

    // Storage: clear sweep has priority; stores are already masked while busy
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[ptr] <= '0;
        end else if (we_c) begin
            mem[widx] <= merged_c;
        end
    end

    assign bus.DM_Out  = dm_out_c;
    assign bus.DM_Busy = busy_c;
    assign bus.SW_EXP  = sw_exp_c;

`ifdef DM_TRACE_EN
    always_ff @(posedge clk) begin
        if (we_c) begin
            $display("%d@%h: *%h <= %h", $time, bus.PC_M, {bus.ALU_Out_M[31:2], 2'b00}, merged_c);
        end
    end
`else
    // PC is only observed by the trace build
    logic pc_unused;
    assign pc_unused = ^bus.PC_M;
`endif
endmodule

// File: tb/tb_dm_store_ram.sv
// Scoreboard bench for dm_store_ram: stimulus queues expectations, a negedge monitor checks them.
module tb_dm_store_ram;
    localparam logic [5:0] OP_NONE = 6'b000000;
    localparam logic [5:0] OP_SB   = 6'b101000;
    localparam logic [5:0] OP_SH   = 6'b101001;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SWL  = 6'b101010;

    typedef struct {
        string       nm;
        logic        chk_data;
        logic [31:0] data;
        logic        sw_exp;
        logic        busy;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic chk_valid;
    int   n_checks;
    int   n_errors;
    exp_t sb_q[$];

    dm_store_ram_if bus ();

    dm_store_ram #(.ADDR_W(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: one expectation consumed per sampled cycle
    always @(negedge clk) begin
        if (chk_valid) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL scoreboard_underflow: got empty queue expected an entry");
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                if (e.chk_data) chk({e.nm, " DM_Out"}, bus.DM_Out, e.data);
                chk({e.nm, " SW_EXP"}, {31'b0, bus.SW_EXP}, {31'b0, e.sw_exp});
                chk({e.nm, " DM_Busy"}, {31'b0, bus.DM_Busy}, {31'b0, e.busy});
            end
        end
    end

    task automatic step(input string nm, input logic [5:0] op, input logic [31:0] addr,
                        input logic [31:0] wd, input logic flush, input logic cd,
                        input logic [31:0] ed, input logic es, input logic eb);
        exp_t e;
        @(posedge clk);
        #1;
        bus.Op        = op;
        bus.ALU_Out_M = addr;
        bus.WD_M      = wd;
        bus.PC_M      = 32'h0040_0000 + addr;
        bus.Flush_M   = flush;
        e = '{nm, cd, ed, es, eb};
        sb_q.push_back(e);
        chk_valid = 1'b1;
    endtask

    task automatic rd(input string nm, input logic [31:0] addr, input logic [31:0] ed);
        step(nm, OP_NONE, addr, 32'h0, 1'b0, 1'b1, ed, 1'b0, 1'b0);
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        bus.Op      = OP_NONE;
        bus.Flush_M = 1'b0;
        chk_valid   = 1'b0;
    endtask

    // Reset held for n edges; release lands just after an edge so ptr=0 is the next window
    task automatic pulse_reset(input string nm, input int n);
        idle();
        reset         = 1'b1;
        bus.ALU_Out_M = 32'h10;
        @(posedge clk);
        #1;
        chk({nm, " busy_in_reset"}, {31'b0, bus.DM_Busy}, 32'h1);
        chk({nm, " out_in_reset"}, bus.DM_Out, 32'h0);
        repeat (n - 1) @(posedge clk);
        if (n > 1) #1;
        reset = 1'b0;
    endtask

    task automatic count_busy(input string nm, input int exp);
        int cnt = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (!bus.DM_Busy) break;
            cnt++;
        end
        chk(nm, 32'(cnt), 32'(exp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b1;
        chk_valid     = 1'b0;
        n_checks      = 0;
        n_errors      = 0;
        bus.Op        = OP_NONE;
        bus.ALU_Out_M = 32'h0;
        bus.WD_M      = 32'h0;
        bus.PC_M      = 32'h0;
        bus.Flush_M   = 1'b0;

        // Power-up clear
        pulse_reset("rst0", 2);
        count_busy("clear_len", 1024);
        rd("rd0_000", 32'h000, 32'h0);
        rd("rd0_010", 32'h010, 32'h0);
        rd("rd0_ffc", 32'hFFC, 32'h0);

        // Word store then byte merge; old word visible during the write
        step("sw_10", OP_SW, 32'h10, 32'h12345678, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
        step("sb_11", OP_SB, 32'h11, 32'h000000AB, 1'b0, 1'b1, 32'h12345678, 1'b0, 1'b0);
        rd("rd_10", 32'h10, 32'h1234AB78);
        rd("rd_13_noalign", 32'h13, 32'h1234AB78);

        // Halfword lanes and misaligned halfword
        step("sh_22", OP_SH, 32'h22, 32'h0000BEEF, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
        rd("rd_20a", 32'h20, 32'hBEEF0000);
        step("sh_21_bad", OP_SH, 32'h21, 32'h00001111, 1'b0, 1'b1, 32'hBEEF0000, 1'b1, 1'b0);
        rd("rd_20b", 32'h20, 32'hBEEF0000);
        step("sh_20", OP_SH, 32'h20, 32'h00005555, 1'b0, 1'b1, 32'hBEEF0000, 1'b0, 1'b0);
        step("sb_23", OP_SB, 32'h23, 32'h00000077, 1'b0, 1'b1, 32'hBEEF5555, 1'b0, 1'b0);
        rd("rd_20c", 32'h20, 32'h77EF5555);

        // Range and alignment of word stores
        step("sw_1000_oor", OP_SW, 32'h1000, 32'hCAFEF00D, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0);
        rd("rd_000", 32'h000, 32'h0);
        step("sw_ffc", OP_SW, 32'hFFC, 32'h0BADF00D, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
        rd("rd_ffc", 32'hFFC, 32'h0BADF00D);
        step("sw_102_bad", OP_SW, 32'h102, 32'h11111111, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0);
        rd("rd_100", 32'h100, 32'h0);
        step("sb_hi_oor", OP_SB, 32'h8000_0010, 32'h00000055, 1'b0, 1'b1, 32'h1234AB78, 1'b1, 1'b0);
        rd("rd_10b", 32'h10, 32'h1234AB78);

        // Flush suppression, flush with illegal store, non-store opcodes
        step("sw_40_flush", OP_SW, 32'h40, 32'hFFFFFFFF, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0);
        rd("rd_40a", 32'h40, 32'h0);
        step("sw_41_flush_bad", OP_SW, 32'h41, 32'h22222222, 1'b1, 1'b1, 32'h0, 1'b1, 1'b0);
        step("lw_41", OP_LW, 32'h41, 32'h33333333, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
        step("swl_40", OP_SWL, 32'h40, 32'h44444444, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
        rd("rd_40b", 32'h40, 32'h0);

        // Reset mid-clear restarts the full sweep
        pulse_reset("rst1", 1);
        repeat (500) @(negedge clk);
        pulse_reset("rst2", 1);
        count_busy("clear_len_restart", 1024);
        rd("rd_ffc_cleared", 32'hFFC, 32'h0);

        // Store to word 0 while the sweep has already passed it must be dropped
        pulse_reset("rst3", 1);
        step("sw_0_busy", OP_SW, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1, 32'h0, 1'b0, 1'b1);
        idle();
        // two of the 1024 clear windows are already behind us here
        count_busy("clear_len_tail", 1022);
        rd("rd_0_dropped", 32'h0, 32'h0);
        rd("rd_10_cleared", 32'h10, 32'h0);
        idle();

        chk("scoreboard_drained", 32'(sb_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
